// File: rtl/counter_nch_if.sv
// Bus-side interface of the N-channel counter: CPU write port and readback port.
// The CPU side uses the master modport; the counter block uses the slave modport.
interface counter_nch_if #(
   parameter int CHW = 2,
   parameter int CW  = 32
);
   logic           counter_we;
   logic           counter_sel;
   logic [CHW-1:0] counter_ch;
   logic [CW-1:0]  counter_val;
   logic [CHW-1:0] counter_rd_ch;
   logic [CW-1:0]  counter_out;

   modport master (
      output counter_we, counter_sel, counter_ch, counter_val, counter_rd_ch,
      input  counter_out
   );

   modport slave (
      input  counter_we, counter_sel, counter_ch, counter_val, counter_rd_ch,
      output counter_out
   );
endinterface

// File: rtl/counter_nch.sv
// N-channel programmable down-counter/timer (one-shot, auto-reload, square-wave).
// Optional per-channel 8-bit prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_nch #(
   parameter int NCH = 4,
   parameter int CHW = 2,
   parameter int CW  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] tick,
   counter_nch_if.slave   bus,
   output logic [NCH-1:0] counter_irq,
   output logic [NCH-1:0] counter_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_ONESHOT     = 2'b00,
      MODE_AUTO        = 2'b01,
      MODE_SQUARE      = 2'b10,
      MODE_ONESHOT_ALT = 2'b11
   } mode_e;

   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   function automatic logic is_oneshot(input mode_e m);
      return (m == MODE_ONESHOT) || (m == MODE_ONESHOT_ALT);
   endfunction

   logic [NCH-1:0] tick_q;
   logic [NCH-1:0] edge_w;
   logic [NCH-1:0] wr_hit;
   logic [NCH-1:0] wr_load;
   logic [NCH-1:0] wr_ctrl;
   logic [NCH-1:0] qual_w;
   logic [NCH-1:0] step_w;

   logic [CW-1:0]  load_q  [NCH];
   logic [CW-1:0]  load_d  [NCH];
   logic [CW-1:0]  cnt_q   [NCH];
   logic [CW-1:0]  cnt_d   [NCH];
   state_e         state_q [NCH];
   state_e         state_d [NCH];
   mode_e          mode_q  [NCH];
   mode_e          mode_d  [NCH];
   logic [NCH-1:0] en_q,   en_d;
   logic [NCH-1:0] irq_q,  irq_d;
   logic [NCH-1:0] busy_q, busy_d;
   logic [CW-1:0]  out_q,  out_d;

`ifdef COUNTER_PRESCALE_EN
   logic [7:0]     presc_q [NCH];
   logic [7:0]     presc_d [NCH];
   logic [7:0]     ps_q    [NCH];
   logic [7:0]     ps_d    [NCH];
`endif

   // A write to a channel swallows any count edge arriving in the same clock.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         edge_w[i]  = tick[i] & ~tick_q[i];
         wr_hit[i]  = bus.counter_we && (bus.counter_ch == CHW'(i));
         wr_load[i] = wr_hit[i] & ~bus.counter_sel;
         wr_ctrl[i] = wr_hit[i] &  bus.counter_sel;
         qual_w[i]  = edge_w[i] & en_q[i] & (state_q[i] == ST_RUN) & ~wr_hit[i];
`ifdef COUNTER_PRESCALE_EN
         step_w[i]  = qual_w[i] & (ps_q[i] == presc_q[i]);
`else
         step_w[i]  = qual_w[i];
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         // NOTE: every next-state value starts as a copy of its register so no path leaves it unassigned (no latch).
         load_d[i]  = load_q[i];
         cnt_d[i]   = cnt_q[i];
         state_d[i] = state_q[i];
         mode_d[i]  = mode_q[i];
         en_d[i]    = en_q[i];
         irq_d[i]   = irq_q[i];
`ifdef COUNTER_PRESCALE_EN
         presc_d[i] = presc_q[i];
         ps_d[i]    = ps_q[i];
`endif

         // The auto-reload terminal pulse lasts a single clock.
         if ((state_q[i] == ST_RUN) && (mode_q[i] == MODE_AUTO)) begin
            irq_d[i] = 1'b0;
         end

         if (wr_load[i]) begin
            load_d[i] = bus.counter_val;
            cnt_d[i]  = bus.counter_val;
            irq_d[i]  = 1'b0;
`ifdef COUNTER_PRESCALE_EN
            ps_d[i]   = '0;
`endif
            if (bus.counter_val != '0) begin
               state_d[i] = ST_RUN;
            end else if (is_oneshot(mode_q[i])) begin
               state_d[i] = ST_DONE;
               irq_d[i]   = 1'b1;
            end else begin
               state_d[i] = ST_IDLE;
            end
         end else if (wr_ctrl[i]) begin
            en_d[i]   = bus.counter_val[0];
            mode_d[i] = mode_e'(bus.counter_val[2:1]);
`ifdef COUNTER_PRESCALE_EN
            presc_d[i] = bus.counter_val[15:8];
            ps_d[i]    = '0;
`endif
         end else if (step_w[i]) begin
`ifdef COUNTER_PRESCALE_EN
            ps_d[i] = '0;
`endif
            if (cnt_q[i] > CNT_ONE) begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (cnt_q[i] == CNT_ONE) begin
               if (is_oneshot(mode_q[i])) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_DONE;
                  irq_d[i]   = 1'b1;
               end else if (mode_q[i] == MODE_AUTO) begin
                  cnt_d[i] = load_q[i];
                  irq_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = load_q[i];
                  irq_d[i] = ~irq_q[i];
               end
            end
`ifdef COUNTER_PRESCALE_EN
         end else if (qual_w[i]) begin
            ps_d[i] = ps_q[i] + 8'd1;
`endif
         end

         busy_d[i] = (state_d[i] == ST_RUN);
      end
   end

   // Readback of an unimplemented channel returns zero.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.counter_rd_ch == CHW'(i)) begin
            out_d = cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= '0;
         en_q   <= '0;
         irq_q  <= '0;
         busy_q <= '0;
         out_q  <= '0;
         // NOTE: the per-channel arrays are flip-flops, not RAM, so they are cleared element by element.
         for (int i = 0; i < NCH; i++) begin
            load_q[i]  <= '0;
            cnt_q[i]   <= '0;
            state_q[i] <= ST_IDLE;
            mode_q[i]  <= MODE_ONESHOT;
`ifdef COUNTER_PRESCALE_EN
            presc_q[i] <= '0;
            ps_q[i]    <= '0;
`endif
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         tick_q <= tick;
         en_q   <= en_d;
         irq_q  <= irq_d;
         busy_q <= busy_d;
         out_q  <= out_d;
         for (int i = 0; i < NCH; i++) begin
            load_q[i]  <= load_d[i];
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
            mode_q[i]  <= mode_d[i];
`ifdef COUNTER_PRESCALE_EN
            presc_q[i] <= presc_d[i];
            ps_q[i]    <= ps_d[i];
`endif
         end
      end
   end

   assign bus.counter_out  = out_q;
   assign counter_irq      = irq_q;
   assign counter_busy     = busy_q;

endmodule

// File: tb/tb_counter_nch.sv
// Self-checking bench for counter_nch: vector table, directed mode sequences, and
// randomized traffic against a behavioural model (honours COUNTER_PRESCALE_EN).
module tb_counter_nch;
   localparam int NCH = 4;
   localparam int CHW = 2;
   localparam int CW  = 32;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] irq;
   logic [NCH-1:0] busy;

   counter_nch_if #(.CHW(CHW), .CW(CW)) bus ();

   counter_nch #(.NCH(NCH), .CHW(CHW), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .bus          (bus),
      .counter_irq  (irq),
      .counter_busy (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit             we;
      bit             sel;
      logic [CHW-1:0] ch;
      logic [CW-1:0]  val;
      logic [NCH-1:0] tk;
      logic [CHW-1:0] rd;
      logic [NCH-1:0] e_irq;
      logic [NCH-1:0] e_busy;
      logic [CW-1:0]  e_out;
   } vec_t;

   vec_t tbl[$];

   // Behavioural model state
   longint m_load [NCH];
   longint m_cnt  [NCH];
   int     m_st   [NCH];
   bit     m_en   [NCH];
   int     m_mode [NCH];
   int     m_p    [NCH];
   int     m_ps   [NCH];
   bit     m_irq  [NCH];
   bit     m_prev [NCH];
   longint m_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit sel, input int ch, input logic [31:0] val);
      bus.counter_we  = 1'b1;
      bus.counter_sel = sel;
      bus.counter_ch  = CHW'(ch);
      bus.counter_val = val;
      cyc();
      bus.counter_we  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input bit we, input bit sel, input int ch, input int val,
                               input logic [3:0] tk, input int rd, input logic [3:0] e_irq,
                               input logic [3:0] e_busy, input int e_out);
      vec_t v;
      v.we = we; v.sel = sel; v.ch = CHW'(ch); v.val = CW'(val);
      v.tk = tk; v.rd = CHW'(rd); v.e_irq = e_irq; v.e_busy = e_busy; v.e_out = CW'(e_out);
      return v;
   endfunction

   function automatic bit oneshot(input int mode);
      return (mode == 0) || (mode == 3);
   endfunction

   task automatic model_step(input bit r, input bit we, input bit sel, input int ch,
                             input logic [31:0] val, input logic [NCH-1:0] tk, input int rd);
      if (r) begin
         for (int c = 0; c < NCH; c++) begin
            m_load[c] = 0; m_cnt[c] = 0; m_st[c] = M_IDLE; m_en[c] = 0; m_mode[c] = 0;
            m_p[c] = 0; m_ps[c] = 0; m_irq[c] = 0; m_prev[c] = 0;
         end
         m_out = 0;
         return;
      end
      m_out = (rd < NCH) ? m_cnt[rd] : 0;
      for (int c = 0; c < NCH; c++) begin
         bit rise;
         bit take;
         rise      = tk[c] && !m_prev[c];
         m_prev[c] = tk[c];
         if (m_st[c] == M_RUN && m_mode[c] == 1) m_irq[c] = 0;
         if (we && ch == c) begin
            if (!sel) begin
               m_load[c] = val; m_cnt[c] = val; m_ps[c] = 0; m_irq[c] = 0;
               if (val != 0)            m_st[c] = M_RUN;
               else if (oneshot(m_mode[c])) begin m_st[c] = M_DONE; m_irq[c] = 1; end
               else                     m_st[c] = M_IDLE;
            end else begin
               m_en[c]   = val[0];
               m_mode[c] = int'(val[2:1]);
               m_p[c]    = int'(val[15:8]);
               m_ps[c]   = 0;
            end
         end else if (rise && m_en[c] && m_st[c] == M_RUN) begin
            take = 1;
`ifdef COUNTER_PRESCALE_EN
            m_ps[c]++;
            if (m_ps[c] <= m_p[c]) take = 0;
            else m_ps[c] = 0;
`endif
            if (take) begin
               if (m_cnt[c] > 1) m_cnt[c]--;
               else if (oneshot(m_mode[c])) begin m_cnt[c] = 0; m_st[c] = M_DONE; m_irq[c] = 1; end
               else if (m_mode[c] == 1) begin m_cnt[c] = m_load[c]; m_irq[c] = 1; end
               else begin m_cnt[c] = m_load[c]; m_irq[c] = !m_irq[c]; end
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_n;
      logic [NCH-1:0] e_irq, e_busy;

      rst = 1'b1;
      tick = '0;
      bus.counter_we = 1'b0; bus.counter_sel = 1'b0; bus.counter_ch = '0;
      bus.counter_val = '0;  bus.counter_rd_ch = '0;

      // Reset held for two clocks with tick toggling
      tick = '1; cyc();
      tick = '0; cyc();
      check("rst irq", 32'(irq), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst out", bus.counter_out, 32'(0));
      rst = 1'b0;

      // ch0: one-shot countdown, then auto with zero/one loads, then write-vs-edge
      tbl.push_back(mk(1,1,0,1, 4'h0,0, 4'h0,4'h0,0));
      tbl.push_back(mk(1,0,0,3, 4'h0,0, 4'h0,4'h1,0));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h0,4'h1,3));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h0,4'h1,2));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h0,4'h1,2));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h0,4'h1,1));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h1,4'h0,1));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h1,4'h0,0));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h1,4'h0,0));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h1,4'h0,0));
      tbl.push_back(mk(1,1,0,3, 4'h0,0, 4'h1,4'h0,0));
      tbl.push_back(mk(1,0,0,0, 4'h0,0, 4'h0,4'h0,0));
      tbl.push_back(mk(1,0,0,1, 4'h0,0, 4'h0,4'h1,0));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h1,4'h1,1));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h0,4'h1,1));
      tbl.push_back(mk(1,1,0,1, 4'h1,0, 4'h0,4'h1,1));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h0,4'h1,1));
      tbl.push_back(mk(0,0,0,0, 4'h1,0, 4'h1,4'h0,1));
      tbl.push_back(mk(0,0,0,0, 4'h0,0, 4'h1,4'h0,0));
      tbl.push_back(mk(1,0,0,0, 4'h0,0, 4'h1,4'h0,0));

      foreach (tbl[i]) begin
         bus.counter_we    = tbl[i].we;
         bus.counter_sel   = tbl[i].sel;
         bus.counter_ch    = tbl[i].ch;
         bus.counter_val   = tbl[i].val;
         tick              = tbl[i].tk;
         bus.counter_rd_ch = tbl[i].rd;
         cyc();
         check($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].e_irq));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
         check($sformatf("vec%0d out", i), bus.counter_out, tbl[i].e_out);
      end
      bus.counter_we = 1'b0;
      tick = '0;

      // ch1 auto-reload, LOAD=2: pulse after every second edge
      bus.counter_rd_ch = 2'd1;
      wr(1'b1, 1, 32'h3);
      wr(1'b0, 1, 32'd2);
      cyc();
      check("auto out load", bus.counter_out, 32'd2);
      for (int k = 1; k <= 6; k++) begin
         tick[1] = 1'b1; cyc();
         check($sformatf("auto irq edge%0d", k), 32'(irq[1]), 32'((k % 2) == 0));
         tick[1] = 1'b0; cyc();
         check($sformatf("auto irq after%0d", k), 32'(irq[1]), 32'(0));
         check($sformatf("auto out%0d", k), bus.counter_out, (k % 2) ? 32'd1 : 32'd2);
      end

      // ch2 square, LOAD=4: output toggles every 4 edges
      wr(1'b1, 2, 32'h5);
      wr(1'b0, 2, 32'd4);
      for (int k = 1; k <= 16; k++) begin
         tick[2] = 1'b1; cyc();
         check($sformatf("sq irq edge%0d", k), 32'(irq[2]), 32'((k / 4) % 2));
         tick[2] = 1'b0; cyc();
      end
      check("ch3 irq", 32'(irq[3]), 32'(0));
      check("ch3 busy", 32'(busy[3]), 32'(0));
      bus.counter_rd_ch = 2'd3; cyc(); cyc();
      check("ch3 out", bus.counter_out, 32'd0);

      // ch0 LOAD coincident with an edge: edge dropped; en=0 freezes count
      bus.counter_rd_ch = 2'd0;
      tick[0] = 1'b1;
      wr(1'b0, 0, 32'd5);
      tick[0] = 1'b0; cyc();
      check("coinc out", bus.counter_out, 32'd5);
      check("coinc irq", 32'(irq[0]), 32'(0));
      check("coinc busy", 32'(busy[0]), 32'(1));
      wr(1'b1, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick[0] = 1'b1; cyc();
         tick[0] = 1'b0; cyc();
      end
      check("frozen out", bus.counter_out, 32'd5);
      check("frozen busy", 32'(busy[0]), 32'(1));

      // Prescaler: CTRL=0x0301, LOAD=2
      do_reset();
      wr(1'b1, 0, 32'h0301);
      wr(1'b0, 0, 32'd2);
`ifdef COUNTER_PRESCALE_EN
      exp_n = 8;
`else
      exp_n = 2;
`endif
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick[0] = 1'b1; cyc();
         n++;
         tick[0] = 1'b0;
         if (irq[0]) break;
         cyc();
      end
      check("prescale edges to irq", 32'(n), 32'(exp_n));
      tick = '0;

      // Randomized traffic against the model
      bus.counter_we = 1'b0;
      rst = 1'b1;
      model_step(1'b1, 1'b0, 1'b0, 0, 32'h0, '0, 0);
      cyc();
      for (int t = 0; t < 1500; t++) begin
         bit r;
         r = ($urandom % 300) == 0;
         rst               = r;
         bus.counter_we    = ($urandom % 6) == 0;
         bus.counter_sel   = $urandom % 2;
         bus.counter_ch    = CHW'($urandom % NCH);
         if (bus.counter_sel)
            bus.counter_val = {$urandom, 8'h00} & 32'hFFFF_F8F8
                              | (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7));
         else
            bus.counter_val = 32'($urandom_range(0, 6));
         tick = NCH'($urandom);
         if (($urandom % 8) == 0) bus.counter_rd_ch = CHW'($urandom % NCH);
         model_step(r, bus.counter_we, bus.counter_sel, int'(bus.counter_ch),
                    bus.counter_val, tick, int'(bus.counter_rd_ch));
         cyc();
         for (int c = 0; c < NCH; c++) begin
            e_irq[c]  = m_irq[c];
            e_busy[c] = (m_st[c] == M_RUN);
         end
         check($sformatf("rnd%0d irq", t), 32'(irq), 32'(e_irq));
         check($sformatf("rnd%0d busy", t), 32'(busy), 32'(e_busy));
         check($sformatf("rnd%0d out", t), bus.counter_out, 32'(m_out));
      end
      rst = 1'b0;
      bus.counter_we = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
